// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: FSM state codes,
// stall-vector encodings and the bundle of combinational control outputs.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_EX_WAIT = 2'b01,
        ST_FLUSH   = 2'b10
    } state_e;

    // Stall bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    typedef struct packed {
        logic [5:0] stall;
        logic       id_ex_bubble;
        logic       ex_abort;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{stall: STALL_NONE, id_ex_bubble: 1'b0, ex_abort: 1'b0};

endpackage

// File: rtl/pipe_ctrl_lu_hazard_det.sv
// Combinational read-after-load hazard check between the ID stage sources and
// a producing stage's destination. Kept generic so it can serve other hazard checks.
module lu_hazard_det #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  src_a_read,
    input  logic                  src_b_read,
    input  logic [REG_ADDR_W-1:0] src_a_addr,
    input  logic [REG_ADDR_W-1:0] src_b_addr,
    input  logic                  dst_we,
    input  logic                  dst_is_load,
    input  logic [REG_ADDR_W-1:0] dst_addr,
    output logic                  hit
);

    logic dst_live;
    logic a_match;
    logic b_match;

    // Register 0 is hardwired to zero, so a write to it never creates a dependency.
    assign dst_live = dst_we & dst_is_load & (dst_addr != '0);
    assign a_match  = src_a_read & (src_a_addr == dst_addr);
    assign b_match  = src_b_read & (src_b_addr == dst_addr);
    assign hit      = dst_live & (a_match | b_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: owns the stall vector, the one-cycle
// flush, the multi-cycle EX watchdog and the saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int EX_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_rs_read,
    input  logic                  id_rt_read,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  ex_we,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_w_addr,
    input  logic                  ex_start,
    input  logic                  ex_done,
    input  logic                  flush_req,
    output logic [5:0]            stall,
    output logic                  id_ex_bubble,
    output logic                  flush,
    output logic                  ex_abort,
    output logic                  ex_timeout,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int                WAIT_W    = (EX_TIMEOUT > 2) ? $clog2(EX_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EX_TIMEOUT - 1);

    state_e            state_q,      state_d;
    logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic              ex_timeout_q, ex_timeout_d;
    ctrl_t             ctrl;
    logic              lu_hit;

    lu_hazard_det #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_lu_hazard_det (
        .src_a_read  (id_rs_read),
        .src_b_read  (id_rt_read),
        .src_a_addr  (id_rs_addr),
        .src_b_addr  (id_rt_addr),
        .dst_we      (ex_we),
        .dst_is_load (ex_is_load),
        .dst_addr    (ex_w_addr),
        .hit         (lu_hit)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        ex_timeout_d = ex_timeout_q;
        ctrl         = CTRL_IDLE;

        unique case (state_q)
            ST_RUN: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end else if (ex_start) begin
                    // A single-cycle completion never needs to hold the front of the pipe.
                    if (!ex_done) begin
                        ctrl.stall = STALL_EX;
                        state_d    = ST_EX_WAIT;
                        wait_cnt_d = '0;
                    end
                end else if (lu_hit) begin
                    ctrl.stall        = STALL_ID;
                    ctrl.id_ex_bubble = 1'b1;
                end
            end
            ST_EX_WAIT: begin
                if (flush_req) begin
                    ctrl.ex_abort = 1'b1;
                    state_d       = ST_FLUSH;
                end else if (ex_done) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    ctrl.ex_abort = 1'b1;
                    ex_timeout_d  = 1'b1;
                    state_d       = ST_RUN;
                end else begin
                    ctrl.stall = STALL_EX;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The multi-cycle unit resets on rst itself, so no abort is issued here.
        if (rst) begin
            ctrl = CTRL_IDLE;
        end

        stall_cnt_d = stall_cnt_q;
        if ((ctrl.stall != STALL_NONE) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wait_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            ex_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            ex_timeout_q <= ex_timeout_d;
        end
    end

    assign stall        = ctrl.stall;
    assign id_ex_bubble = ctrl.id_ex_bubble;
    assign ex_abort     = ctrl.ex_abort;
    assign flush        = (state_q == ST_FLUSH) & ~rst;
    assign ex_timeout   = ex_timeout_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver issues directed and random cycles and
// queues model predictions; a negedge monitor pops and compares both DUT instances.
module tb_pipe_ctrl;

    localparam int REG_ADDR_W = 5;
    localparam int EX_TIMEOUT = 64;

    typedef struct packed {
        logic       rst;
        logic       ex_start;
        logic       ex_done;
        logic       flush_req;
        logic       id_rs_read;
        logic       id_rt_read;
        logic       ex_we;
        logic       ex_is_load;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wa;
    } in_t;

    typedef struct {
        bit          flushing;
        bit          busy;
        int          start_cyc;
        bit          tmo;
        longint      cnt;
    } model_t;

    typedef struct {
        logic [5:0]  stall;
        bit          bubble;
        bit          flush;
        bit          abort;
        bit          tmo;
        longint      cnt;
    } exp_t;

    typedef struct {
        int   cyc;
        exp_t a;
        exp_t b;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_rs_read = 1'b0, id_rt_read = 1'b0;
    logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, ex_w_addr = '0;
    logic        ex_we = 1'b0, ex_is_load = 1'b0, ex_start = 1'b0, ex_done = 1'b0, flush_req = 1'b0;

    logic [5:0]  a_stall, b_stall;
    logic        a_bubble, b_bubble, a_flush, b_flush, a_abort, b_abort, a_tmo, b_tmo;
    logic [31:0] a_cnt;
    logic [3:0]  b_cnt;

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    sb_t    sb_q[$];
    sb_t    mon_s;
    model_t ma, mb;

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_ADDR_W(REG_ADDR_W), .EX_TIMEOUT(EX_TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs_read(id_rs_read), .id_rt_read(id_rt_read),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_w_addr(ex_w_addr),
        .ex_start(ex_start), .ex_done(ex_done), .flush_req(flush_req),
        .stall(a_stall), .id_ex_bubble(a_bubble), .flush(a_flush),
        .ex_abort(a_abort), .ex_timeout(a_tmo), .stall_cnt(a_cnt)
    );

    pipe_ctrl #(.REG_ADDR_W(REG_ADDR_W), .EX_TIMEOUT(EX_TIMEOUT), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs_read(id_rs_read), .id_rt_read(id_rt_read),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_w_addr(ex_w_addr),
        .ex_start(ex_start), .ex_done(ex_done), .flush_req(flush_req),
        .stall(b_stall), .id_ex_bubble(b_bubble), .flush(b_flush),
        .ex_abort(b_abort), .ex_timeout(b_tmo), .stall_cnt(b_cnt)
    );

    task automatic check(input string name, input int at, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, at, act, exp);
        end
    endtask

    // Reference behaviour: a multi-cycle op holds the front of the pipe until it
    // completes, is flushed, or EX_TIMEOUT cycles have passed since it started.
    function automatic void model_step(input model_t m, input in_t x, input int now,
                                       input longint cmax, output model_t nm, output exp_t e);
        bit lu;
        nm       = m;
        e.stall  = 6'b000000;
        e.bubble = 1'b0;
        e.flush  = 1'b0;
        e.abort  = 1'b0;
        e.tmo    = m.tmo;
        e.cnt    = m.cnt;
        if (x.rst) begin
            nm.flushing = 1'b0;
            nm.busy     = 1'b0;
            nm.tmo      = 1'b0;
            nm.cnt      = 0;
            return;
        end
        lu = x.ex_we && x.ex_is_load && (x.wa != 0) &&
             ((x.id_rs_read && x.rs == x.wa) || (x.id_rt_read && x.rt == x.wa));
        if (m.flushing) begin
            e.flush     = 1'b1;
            nm.flushing = 1'b0;
        end else if (m.busy) begin
            if (x.flush_req) begin
                e.abort     = 1'b1;
                nm.busy     = 1'b0;
                nm.flushing = 1'b1;
            end else if (x.ex_done) begin
                nm.busy = 1'b0;
            end else if (now - m.start_cyc >= EX_TIMEOUT) begin
                e.abort = 1'b1;
                nm.tmo  = 1'b1;
                nm.busy = 1'b0;
            end else begin
                e.stall = 6'b001111;
            end
        end else if (x.flush_req) begin
            nm.flushing = 1'b1;
        end else if (x.ex_start) begin
            if (!x.ex_done) begin
                e.stall      = 6'b001111;
                nm.busy      = 1'b1;
                nm.start_cyc = now;
            end
        end else if (lu) begin
            e.stall  = 6'b000111;
            e.bubble = 1'b1;
        end
        if (e.stall != 0 && m.cnt < cmax) nm.cnt = m.cnt + 1;
    endfunction

    task automatic drive(input in_t x);
        sb_t    s;
        model_t na, nb;
        @(posedge clk);
        #1;
        rst        = x.rst;
        ex_start   = x.ex_start;
        ex_done    = x.ex_done;
        flush_req  = x.flush_req;
        id_rs_read = x.id_rs_read;
        id_rt_read = x.id_rt_read;
        ex_we      = x.ex_we;
        ex_is_load = x.ex_is_load;
        id_rs_addr = x.rs;
        id_rt_addr = x.rt;
        ex_w_addr  = x.wa;
        model_step(ma, x, cyc, 64'h0000_0000_FFFF_FFFF, na, s.a);
        model_step(mb, x, cyc, 15, nb, s.b);
        s.cyc = cyc;
        ma    = na;
        mb    = nb;
        cyc++;
        sb_q.push_back(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_s = sb_q.pop_front();
            check("stall",      mon_s.cyc, 64'(a_stall),  64'(mon_s.a.stall));
            check("bubble",     mon_s.cyc, 64'(a_bubble), 64'(mon_s.a.bubble));
            check("flush",      mon_s.cyc, 64'(a_flush),  64'(mon_s.a.flush));
            check("ex_abort",   mon_s.cyc, 64'(a_abort),  64'(mon_s.a.abort));
            check("ex_timeout", mon_s.cyc, 64'(a_tmo),    64'(mon_s.a.tmo));
            check("stall_cnt",  mon_s.cyc, 64'(a_cnt),    64'(mon_s.a.cnt));
            check("sat_stall",  mon_s.cyc, 64'(b_stall),  64'(mon_s.b.stall));
            check("sat_abort",  mon_s.cyc, 64'(b_abort),  64'(mon_s.b.abort));
            check("sat_cnt",    mon_s.cyc, 64'(b_cnt),    64'(mon_s.b.cnt));
        end
    end

    initial begin
        in_t x;
        int  guard;
        ma = '{default: 0};
        mb = '{default: 0};
        repeat (2) @(posedge clk);

        x = '0; x.rst = 1'b1;
        drive(x); drive(x);
        idle(2);

        // Load-use into $5 read as rs, then the same against $0, then a non-load producer.
        x = '0; x.ex_we = 1; x.ex_is_load = 1; x.wa = 5; x.id_rs_read = 1; x.rs = 5;
        drive(x); idle(1);
        x.wa = 0; x.rs = 0;
        drive(x); idle(1);
        x = '0; x.ex_we = 1; x.wa = 7; x.id_rs_read = 1; x.rs = 7;
        drive(x); idle(1);
        x = '0; x.ex_we = 1; x.ex_is_load = 1; x.wa = 9; x.id_rt_read = 1; x.rt = 9;
        drive(x); idle(1);

        // Multi-cycle op completing 35 cycles after it started.
        x = '0; x.rst = 1; drive(x);
        x = '0; x.ex_start = 1; drive(x);
        idle(34);
        x = '0; x.ex_done = 1; drive(x);
        idle(1);
        check("mc_stall_cnt", cyc, 64'(a_cnt), 64'd35);
        check("mc_sat_cnt",   cyc, 64'(b_cnt), 64'd15);

        // Start and done in the same cycle never stalls.
        x = '0; x.ex_start = 1; x.ex_done = 1; drive(x); idle(1);

        // Watchdog: no completion.
        x = '0; x.rst = 1; drive(x);
        x = '0; x.ex_start = 1; drive(x);
        idle(70);
        check("wd_timeout",   cyc, 64'(a_tmo), 64'd1);
        check("wd_stall_cnt", cyc, 64'(a_cnt), 64'd64);
        x = '0; x.ex_start = 1; drive(x);
        x = '0; x.ex_done = 1; drive(x);
        idle(3);
        check("wd_sticky", cyc, 64'(a_tmo), 64'd1);

        // Flush beats ex_start and lu_hit; requests during FLUSH are ignored.
        x = '0; x.flush_req = 1; x.ex_start = 1; x.ex_we = 1; x.ex_is_load = 1;
        x.wa = 3; x.id_rs_read = 1; x.rs = 3;
        drive(x); drive(x);
        idle(1);
        x = '0; x.ex_start = 1; drive(x);
        idle(4);
        x = '0; x.flush_req = 1; x.ex_done = 1; drive(x);
        idle(2);

        // Reset in the middle of a multi-cycle wait.
        x = '0; x.ex_start = 1; drive(x);
        idle(5);
        x = '0; x.rst = 1; drive(x);
        idle(1);
        check("rst_stall_cnt", cyc, 64'(a_cnt), 64'd0);
        check("rst_timeout",   cyc, 64'(a_tmo), 64'd0);

        for (int i = 0; i < 2500; i++) begin
            x            = '0;
            x.rst        = ($urandom_range(0, 399) == 0);
            x.ex_start   = ($urandom_range(0, 9) == 0);
            x.ex_done    = ($urandom_range(0, 29) == 0);
            x.flush_req  = ($urandom_range(0, 49) == 0);
            x.id_rs_read = 1'($urandom_range(0, 1));
            x.id_rt_read = 1'($urandom_range(0, 1));
            x.ex_we      = 1'($urandom_range(0, 1));
            x.ex_is_load = 1'($urandom_range(0, 1));
            x.rs         = 5'($urandom_range(0, 3));
            x.rt         = 5'($urandom_range(0, 3));
            x.wa         = 5'($urandom_range(0, 3));
            drive(x);
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
